// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares one single-port framebuffer RAM between the scan-out read path and
// the capture write path. Writes are queued in a small FIFO and drained into
// RAM whenever the read path leaves a slot free; a starvation counter forces a
// write through (pre-empting a read) if the queue has waited too long.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   rd_req/rd_addr  : scan-out read request and pixel address
//   rd_data         : read pixel data, fixed latency 3 after rd_req
//   rd_valid        : rd_data valid this cycle
//   rd_miss         : with rd_valid, the read lost its slot and rd_data is 0
//   wr_req/wr_addr/wr_data : capture write request (no backpressure)
//   ram_addr/ram_wdata/ram_we : registered single-port RAM controls
//   ram_rdata       : RAM read data, one cycle after ram_addr
//   fifo_level      : write-queue occupancy after the current edge
//   overflow_cnt    : saturating count of dropped writes
module fb_port_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic [1:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_miss,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic [14:0] ram_addr,
  output logic [1:0]  ram_wdata,
  output logic        ram_we,
  input  logic [1:0]  ram_rdata,
  output logic [4:0]  fifo_level,
  output logic [7:0]  overflow_cnt
);

  localparam int         PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_LVL  = 5'(FIFO_DEPTH);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE,
    SLOT_FORCED
  } slot_e;

  logic [16:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [16:0]      fifo_head;
  logic [7:0]       starve_cnt;
  slot_e            slot;
  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;
  logic             rd_p1;
  logic             miss_p1;
  logic             rd_p2;
  logic             miss_p2;

  // Slot choice for this cycle. A starved queue beats the reader; otherwise
  // the reader wins and queued writes only fill otherwise idle slots. A full
  // queue can still accept a push in the same cycle it pops.
  always_comb begin
    fifo_empty = (fifo_level == 5'd0);
    fifo_full  = (fifo_level == DEPTH_LVL);
    fifo_head  = fifo_mem[rd_ptr];
    slot       = SLOT_IDLE;
    if (!fifo_empty && (starve_cnt == STARVE_MAX)) begin
      slot = SLOT_FORCED;
    end else if (rd_req) begin
      slot = SLOT_READ;
    end else if (!fifo_empty) begin
      slot = SLOT_WRITE;
    end
    do_pop  = (slot == SLOT_FORCED) || (slot == SLOT_WRITE);
    do_push = wr_req && (!fifo_full || do_pop);
    do_drop = wr_req && fifo_full && !do_pop;
  end

  // Queue storage. Entries are only meaningful between rd_ptr and wr_ptr, so
  // the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      fifo_mem[wr_ptr] <= {wr_addr, wr_data};
    end
  end

  // Queue pointers, occupancy and the saturating drop counter. Requests seen
  // while rst is high are ignored because the reset branch takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= 5'd0;
      overflow_cnt <= 8'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
      if (do_drop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  // Starvation counter: counts consecutive cycles a non-empty queue was
  // refused a slot. Reaching STARVE_MAX forces the next slot, which clears it,
  // so the hold at STARVE_MAX is only a guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (fifo_empty || do_pop) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // RAM port register. Idle slots deassert the write enable but keep the last
  // address and data on the bus to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= 15'd0;
      ram_wdata <= 2'b00;
      ram_we    <= 1'b0;
    end else begin
      case (slot)
        SLOT_FORCED, SLOT_WRITE: begin
          ram_addr  <= fifo_head[16:2];
          ram_wdata <= fifo_head[1:0];
          ram_we    <= 1'b1;
        end
        SLOT_READ: begin
          ram_addr <= rd_addr;
          ram_we   <= 1'b0;
        end
        default: begin
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipeline: stage 1 lines up with ram_addr, stage 2 with
  // ram_rdata, and the output stage registers the data. A pre-empted read
  // still walks the pipe so the reader sees a fixed latency, but it returns
  // zero data flagged as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1    <= 1'b0;
      miss_p1  <= 1'b0;
      rd_p2    <= 1'b0;
      miss_p2  <= 1'b0;
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
      rd_data  <= 2'b00;
    end else begin
      rd_p1    <= rd_req;
      miss_p1  <= rd_req && (slot == SLOT_FORCED);
      rd_p2    <= rd_p1;
      miss_p2  <= miss_p1;
      rd_valid <= rd_p2;
      rd_miss  <= miss_p2;
      rd_data  <= (rd_p2 && !miss_p2) ? ram_rdata : 2'b00;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
// Directed bench for fb_port_arbiter with default parameters (depth 4,
// starvation limit 8). Includes a behavioural single-port RAM with one cycle
// read latency and read-before-write behaviour, plus a log of every RAM write.
module tb_fb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic [1:0]  rd_data;
  logic        rd_valid;
  logic        rd_miss;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic [14:0] ram_addr;
  logic [1:0]  ram_wdata;
  logic        ram_we;
  logic [1:0]  ram_rdata;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  logic        pre_we;
  logic [14:0] pre_addr;
  logic [1:0]  pre_data;
  logic [1:0]  mem [32768];
  logic [16:0] wr_log [$];

  int tests;
  int failures;
  int base;
  logic        tb_rd;
  logic        tb_wr;
  logic [14:0] tb_wa;
  logic [1:0]  tb_wd;

  fb_port_arbiter #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_miss     (rd_miss),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .fifo_level  (fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: registered read of the old contents, write on
  // ram_we, and a bench-only preload port used while the DUT is in reset.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Record every write the DUT presents to RAM, in order.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_log.push_back({ram_addr, ram_wdata});
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, then return just after the edge that sampled
  // them, so the DUT outputs of that edge are visible.
  task automatic applyStimulus(input logic rd, input logic [14:0] ra,
                               input logic wr, input logic [14:0] wa,
                               input logic [1:0] wd);
    rd_req  = rd;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = 15'd0;
    wr_req   = 1'b0;
    wr_addr  = 15'd0;
    wr_data  = 2'b00;
    ram_rdata = 2'b00;

    // Preload RAM while in reset: 0x0050 holds 01, 0x0200 holds 11.
    pre_we   = 1'b1;
    pre_addr = 15'h0050;
    pre_data = 2'b01;
    @(posedge clk); #1;
    pre_addr = 15'h0200;
    pre_data = 2'b11;
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(posedge clk); #1;

    checkOutput("reset ram_we",       32'(ram_we),       32'd0);
    checkOutput("reset ram_addr",     32'(ram_addr),     32'd0);
    checkOutput("reset ram_wdata",    32'(ram_wdata),    32'd0);
    checkOutput("reset rd_valid",     32'(rd_valid),     32'd0);
    checkOutput("reset rd_miss",      32'(rd_miss),      32'd0);
    checkOutput("reset rd_data",      32'(rd_data),      32'd0);
    checkOutput("reset fifo_level",   32'(fifo_level),   32'd0);
    checkOutput("reset overflow_cnt", 32'(overflow_cnt), 32'd0);
    rst = 1'b0;

    // Single write, no reads: RAM write two cycles after the request.
    applyStimulus(1'b0, 15'd0, 1'b1, 15'h1234, 2'b10);
    checkOutput("wr1 level after push", 32'(fifo_level), 32'd1);
    checkOutput("wr1 no early we",      32'(ram_we),     32'd0);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    checkOutput("wr1 ram_we",     32'(ram_we),     32'd1);
    checkOutput("wr1 ram_addr",   32'(ram_addr),   32'h1234);
    checkOutput("wr1 ram_wdata",  32'(ram_wdata),  32'd2);
    checkOutput("wr1 level drain", 32'(fifo_level), 32'd0);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    checkOutput("idle we low",    32'(ram_we),   32'd0);
    checkOutput("idle addr hold", 32'(ram_addr), 32'h1234);

    // Reads every 4th cycle interleaved with writes.
    base = wr_log.size();
    for (int i = 0; i < 12; i++) begin
      tb_rd = ((i % 4) == 0) && (i < 8);
      tb_wr = 1'b0;
      tb_wa = 15'd0;
      tb_wd = 2'b00;
      if (i == 1) begin tb_wr = 1'b1; tb_wa = 15'h0100; tb_wd = 2'b11; end
      if (i == 2) begin tb_wr = 1'b1; tb_wa = 15'h0101; tb_wd = 2'b10; end
      if (i == 5) begin tb_wr = 1'b1; tb_wa = 15'h0102; tb_wd = 2'b01; end
      applyStimulus(tb_rd, 15'h0050, tb_wr, tb_wa, tb_wd);
      if (i == 2 || i == 6) begin
        checkOutput("mix rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("mix rd_data",  32'(rd_data),  32'd1);
        checkOutput("mix rd_miss",  32'(rd_miss),  32'd0);
      end else begin
        checkOutput("mix rd_valid idle", 32'(rd_valid), 32'd0);
      end
    end
    checkOutput("mix write count", 32'(wr_log.size() - base), 32'd3);
    checkOutput("mix write 0", 32'(wr_log[base + 0]), 32'({15'h0100, 2'b11}));
    checkOutput("mix write 1", 32'(wr_log[base + 1]), 32'({15'h0101, 2'b10}));
    checkOutput("mix write 2", 32'(wr_log[base + 2]), 32'({15'h0102, 2'b01}));
    checkOutput("mix level",   32'(fifo_level), 32'd0);

    // Continuous reads plus one write: forced write in the 9th cycle after the
    // push pre-empts that cycle's read.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(i < 12, 15'h0050, i == 0, 15'h0200, 2'b10);
      checkOutput("starve ram_we", 32'(ram_we), 32'(i == 9));
      if (i == 9) begin
        checkOutput("starve ram_addr",  32'(ram_addr),   32'h0200);
        checkOutput("starve ram_wdata", 32'(ram_wdata),  32'd2);
        checkOutput("starve level",     32'(fifo_level), 32'd0);
      end
      if (i == 11) begin
        checkOutput("starve miss valid", 32'(rd_valid), 32'd1);
        checkOutput("starve miss flag",  32'(rd_miss),  32'd1);
        checkOutput("starve miss data",  32'(rd_data),  32'd0);
      end
      if (i == 10 || i == 12) begin
        checkOutput("starve hit valid", 32'(rd_valid), 32'd1);
        checkOutput("starve hit flag",  32'(rd_miss),  32'd0);
        checkOutput("starve hit data",  32'(rd_data),  32'd1);
      end
    end

    // Six writes into a depth-4 queue while reads hog the port.
    base = wr_log.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 15'h0050, 1'b1, 15'(15'h0300 + i), 2'(i));
    end
    checkOutput("ovf level",    32'(fifo_level),   32'd4);
    checkOutput("ovf count",    32'(overflow_cnt), 32'd2);
    checkOutput("ovf no write", 32'(wr_log.size() - base), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    end
    checkOutput("ovf drained level", 32'(fifo_level), 32'd0);
    checkOutput("ovf write count", 32'(wr_log.size() - base), 32'd4);
    for (int j = 0; j < 4; j++) begin
      checkOutput("ovf write order", 32'(wr_log[base + j]),
                  32'({15'(15'h0300 + j), 2'(j)}));
    end

    // Fill to 4, then push and pop together.
    base = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 15'h0050, 1'b1, 15'(15'h0500 + i), 2'(3 - i));
    end
    checkOutput("full level", 32'(fifo_level), 32'd4);
    applyStimulus(1'b0, 15'd0, 1'b1, 15'h0510, 2'b01);
    checkOutput("pushpop level",    32'(fifo_level),   32'd4);
    checkOutput("pushpop overflow", 32'(overflow_cnt), 32'd2);
    checkOutput("pushpop ram_we",   32'(ram_we),       32'd1);
    checkOutput("pushpop ram_addr", 32'(ram_addr),     32'h0500);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    end
    checkOutput("pushpop drained", 32'(fifo_level), 32'd0);
    checkOutput("pushpop write count", 32'(wr_log.size() - base), 32'd5);
    checkOutput("pushpop first", 32'(wr_log[base + 0]), 32'({15'h0500, 2'b11}));
    checkOutput("pushpop last",  32'(wr_log[base + 4]), 32'({15'h0510, 2'b01}));

    // Reset with queued writes and reads in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 15'h0050, 1'b1, 15'(15'h0600 + i), 2'b11);
    end
    checkOutput("pre-rst level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    applyStimulus(1'b1, 15'h0050, 1'b1, 15'h0700, 2'b01);
    checkOutput("rst level",     32'(fifo_level),   32'd0);
    checkOutput("rst overflow",  32'(overflow_cnt), 32'd0);
    checkOutput("rst ram_we",    32'(ram_we),       32'd0);
    checkOutput("rst ram_addr",  32'(ram_addr),     32'd0);
    checkOutput("rst ram_wdata", 32'(ram_wdata),    32'd0);
    checkOutput("rst rd_valid",  32'(rd_valid),     32'd0);
    checkOutput("rst rd_miss",   32'(rd_miss),      32'd0);
    checkOutput("rst rd_data",   32'(rd_data),      32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 15'd0, 1'b1, 15'h0400, 2'b01);
    checkOutput("post-rst we A",    32'(ram_we),     32'd0);
    checkOutput("post-rst valid A", 32'(rd_valid),   32'd0);
    checkOutput("post-rst level A", 32'(fifo_level), 32'd1);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    checkOutput("post-rst we B",    32'(ram_we),   32'd1);
    checkOutput("post-rst addr B",  32'(ram_addr), 32'h0400);
    checkOutput("post-rst valid B", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0, 2'b00);
    checkOutput("post-rst we C",    32'(ram_we),     32'd0);
    checkOutput("post-rst valid C", 32'(rd_valid),   32'd0);
    checkOutput("post-rst level C", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
